muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage. Sits directly downstream of the ALU operand-select mux and consumes its two 32-bit operand outputs (A = rs1 path, B = rs2 path) in parallel with the single-cycle ALU.
- Latches both operands on request, because forwarded values feeding the mux change as the pipeline advances.
- Runs a 32-iteration shift/add multiply or restoring divide, then presents one result word.
- Drives a stall back to the hazard logic until the result is available.

---
 rtl/core_pkg.sv | 27 ++
 rtl/muldiv_signfix.sv | 49 ++++
 rtl/muldiv_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the EX-stage M-extension datapath.
//   XLEN          : architectural register width
//   OP_*          : funct3 encodings of the eight RV32M operations
//   state_e       : sequencing states of the iterative multiply/divide unit
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// Combinational sign handling around the unsigned multiply/divide core.
// Operand side: decides which operands are signed for the given funct3 and
// produces their magnitudes plus negative flags. Result side: conditionally
// two's-complement negates a double-width raw result.
//   op_i     : funct3 of the operation whose operands are on a_i/b_i
//   a_i, b_i : raw operands
//   a_mag_o, b_mag_o : magnitudes (unchanged for unsigned interpretation)
//   a_neg_o, b_neg_o : operand is signed and negative
//   raw_i    : unsigned result from the iterative core
//   neg_i    : negate raw_i
//   fixed_o  : signed-corrected result
// -----------------------------------------------------------------------------
module muldiv_signfix
  import core_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   a_mag_o,
  output logic [WIDTH-1:0]   b_mag_o,
  output logic               a_neg_o,
  output logic               b_neg_o,
  input  logic [2*WIDTH-1:0] raw_i,
  input  logic               neg_i,
  output logic [2*WIDTH-1:0] fixed_o
);

  logic a_signed;
  logic b_signed;

  always_comb begin
    // MULHSU treats only A as signed; MULHU, DIVU, REMU and MUL are unsigned.
    a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV)  || (op_i == OP_REM);
    b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);

    a_neg_o  = a_signed && a_i[WIDTH-1];
    b_neg_o  = b_signed && b_i[WIDTH-1];
    a_mag_o  = a_neg_o ? -a_i : a_i;
    b_mag_o  = b_neg_o ? -b_i : b_i;

    fixed_o  = neg_i ? -raw_i : raw_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU.
// Operands are latched on accept, then 32 shift/add (multiply) or restoring
// subtract (divide) iterations run, one per cycle. Divide-by-zero and the
// signed overflow case finish in one cycle without iterating.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : M-op in EX with valid operands
//   kill_i     : pipeline flush, aborts any operation
//   op_i       : funct3 of the M-op
//   a_i, b_i   : rs1 / rs2 operands from the operand mux
//   result_o   : result, held from done until the next completed op
//   done_o     : one-cycle result-valid pulse
//   busy_o     : unit not idle
//   stall_o    : hold IF/ID/EX
// -----------------------------------------------------------------------------
module muldiv_unit
  import core_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             stall_o
);

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 fast_done_q, fast_done_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 a_neg, b_neg;
  logic                 accept;
  logic                 is_fast;
  logic [WIDTH-1:0]     fast_result;
  logic                 b_zero, div_ovf;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;
  logic [WIDTH-1:0]     rem_next, quo_next;
  logic [2*WIDTH-1:0]   fix_raw, fix_out;
  logic [WIDTH-1:0]     final_result;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .a_mag_o (a_mag),
    .b_mag_o (b_mag),
    .a_neg_o (a_neg),
    .b_neg_o (b_neg),
    .raw_i   (fix_raw),
    .neg_i   (neg_q),
    .fixed_o (fix_out)
  );

  // Fast-path decision on the live operands; only used in the accept cycle.
  always_comb begin
    b_zero      = (b_i == '0);
    div_ovf     = (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
    is_fast     = 1'b0;
    fast_result = '0;
    case (op_i)
      OP_DIV: begin
        is_fast     = b_zero || div_ovf;
        fast_result = b_zero ? '1 : a_i;
      end
      OP_DIVU: begin
        is_fast     = b_zero;
        fast_result = '1;
      end
      OP_REM: begin
        is_fast     = b_zero || div_ovf;
        fast_result = b_zero ? a_i : '0;
      end
      OP_REMU: begin
        is_fast     = b_zero;
        fast_result = a_i;
      end
      default: begin
        is_fast     = 1'b0;
        fast_result = '0;
      end
    endcase
  end

  // One iteration of each algorithm. Multiply keeps B in the low half of the
  // product register and shifts the accumulated sum in from the top. Divide
  // keeps the dividend/quotient in the low half of the same register and
  // shifts dividend bits into the partial remainder. When the 33-bit shifted
  // remainder is >= divisor the true difference fits in WIDTH bits, so the
  // subtraction only needs the low WIDTH bits.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next  = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]}
                          : {1'b0, prod_q[2*WIDTH-1:1]};

    div_shift = {rem_q, prod_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    rem_next  = div_ge ? div_sub : div_shift[WIDTH-1:0];
    quo_next  = {prod_q[WIDTH-2:0], div_ge};

    if (op_q[2]) begin
      fix_raw = {{WIDTH{1'b0}}, (op_q[1] ? rem_next : quo_next)};
    end else begin
      fix_raw = mul_next;
    end

    // MUL and all divide ops take the low word; MULH variants the high word.
    if (op_q[2] || (op_q[1:0] == 2'b00)) begin
      final_result = fix_out[WIDTH-1:0];
    end else begin
      final_result = fix_out[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic. Kill wins over everything, including a same-cycle start.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    prod_d      = prod_q;
    rem_d       = rem_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    fast_done_d = 1'b0;
    accept      = start_i && !kill_i && (state_q != RUN);

    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            op_d  = op_i;
            cnt_d = '0;
            rem_d = '0;
            // Remainder takes the dividend's sign; products and quotients
            // take the XOR of both signs.
            neg_d = ((op_i == OP_REM) || (op_i == OP_REMU)) ? a_neg
                                                             : (a_neg ^ b_neg);
            if (op_i[2]) begin
              opnd_d = b_mag;
              prod_d = {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd_d = a_mag;
              prod_d = {{WIDTH{1'b0}}, b_mag};
            end
            if (is_fast) begin
              state_d     = DONE;
              result_d    = fast_result;
              fast_done_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (op_q[2]) begin
            prod_d = {{WIDTH{1'b0}}, quo_next};
            rem_d  = rem_next;
          end else begin
            prod_d = mul_next;
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = DONE;
            result_d = final_result;
            cnt_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      prod_q      <= '0;
      rem_q       <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      fast_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      prod_q      <= prod_d;
      rem_q       <= rem_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      fast_done_q <= fast_done_d;
    end
  end

  assign result_o = result_q;
  assign done_o   = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);
  // The DONE cycle of a fast-path op must not stall again, so the requesting
  // instruction sees exactly one stall cycle.
  assign stall_o  = rst_n && ((accept && !fast_done_q) || (state_q == RUN));

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: a table of directed vectors, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for kill, reset and back-to-back behaviour.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        kill_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] result_o;
  logic        done_o;
  logic        busy_o;
  logic        stall_o;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .kill_i   (kill_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .result_o (result_o),
    .done_o   (done_o),
    .busy_o   (busy_o),
    .stall_o  (stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Reference model straight from the RV32M definitions using wide arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_MUL: begin
        up = {32'd0, a} * {32'd0, b};
        return up[31:0];
      end
      OP_MULH: begin
        sp = longint'(sa) * longint'(sb);
        up = sp;
        return up[63:32];
      end
      OP_MULHSU: begin
        sp = longint'(sa) * longint'({32'd0, b});
        up = sp;
        return up[63:32];
      end
      OP_MULHU: begin
        up = {32'd0, a} * {32'd0, b};
        return up[63:32];
      end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Issue one request in the current cycle and wait (bounded) for done_o,
  // counting stall cycles from the request cycle through the done cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit scramble,
                               output logic [31:0] res, output int lat,
                               output int stall_cycles, output bit timed_out);
    start_i = 1'b1;
    kill_i  = 1'b0;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    #1;
    stall_cycles = stall_o ? 1 : 0;
    lat       = 0;
    timed_out = 1'b1;
    res       = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (scramble) begin
        a_i = $urandom;
        b_i = $urandom;
      end
      #1;
      if (stall_o) stall_cycles++;
      if (done_o) begin
        lat       = c;
        res       = result_o;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic runAndCheck(input string name, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input int exp_lat,
                             input bit scramble, input bit idle_after);
    logic [31:0] res;
    int          lat;
    int          stalls;
    bit          to;
    applyStimulus(op, a, b, scramble, res, lat, stalls, to);
    if (to) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.timeout actual=no_done required=done_within_40", name);
    end
    checkOutput({name, ".res"}, res, exp_res);
    checkOutput({name, ".lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, ".stall"}, 32'(stalls), 32'(exp_lat));
    if (idle_after) begin
      @(posedge clk);
      #2;
      checkOutput({name, ".pulse"}, {31'd0, done_o}, 32'd0);
      checkOutput({name, ".hold"}, result_o, exp_res);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          done_seen;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{"mul_7_m3",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{"mulh_min",    OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{"mulhu_max",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{"mulhsu_m1",   OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[4]  = '{"div_m7_2",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{"rem_m7_2",    OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{"remu_100_7",  OP_REMU,   32'd100,        32'd7,         32'd2,         33};
    vecs[7]  = '{"divu_5_0",    OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[8]  = '{"rem_5_0",     OP_REM,    32'd5,          32'd0,         32'd5,         1};
    vecs[9]  = '{"div_ovf",     OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[10] = '{"rem_ovf",     OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[11] = '{"div_0_0",     OP_DIV,    32'd0,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[12] = '{"mul_lowword", OP_MUL,    32'h1234_5678,  32'h0000_1000, 32'h4567_8000, 33};
    vecs[13] = '{"divu_100_7",  OP_DIVU,   32'd100,        32'd7,         32'd14,        33};

    // Reset state, including stall suppression while reset is asserted.
    rst_n   = 1'b0;
    start_i = 1'b1;
    kill_i  = 1'b0;
    op_i    = OP_MUL;
    a_i     = 32'd3;
    b_i     = 32'd4;
    #2;
    checkOutput("reset.result", result_o, 32'd0);
    checkOutput("reset.done",   {31'd0, done_o},  32'd0);
    checkOutput("reset.busy",   {31'd0, busy_o},  32'd0);
    checkOutput("reset.stall",  {31'd0, stall_o}, 32'd0);
    start_i = 1'b0;
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed table");
    foreach (vecs[i]) begin
      runAndCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp_res, vecs[i].exp_lat, 1'b0, 1'b1);
    end

    // Kill at T+10 of a DIV: back to idle, no done, previous result (14) kept.
    $display("[TB] kill sequence");
    done_seen = 0;
    start_i = 1'b1;
    op_i    = OP_DIV;
    a_i     = 32'd1000;
    b_i     = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (c == 10) kill_i = 1'b1;
      #1;
      if (done_o) done_seen++;
    end
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    #1;
    checkOutput("kill.done_seen", 32'(done_seen), 32'd0);
    checkOutput("kill.busy",   {31'd0, busy_o}, 32'd0);
    checkOutput("kill.done",   {31'd0, done_o}, 32'd0);
    checkOutput("kill.result", result_o, 32'd14);
    @(posedge clk);
    #1;
    runAndCheck("after_kill", OP_DIV, 32'd1000, 32'd3, 32'd333, 33, 1'b0, 1'b1);

    // Kill in the same cycle as start: no accept.
    kill_i  = 1'b1;
    start_i = 1'b1;
    op_i    = OP_MUL;
    #1;
    checkOutput("kill_start.stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    kill_i  = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("kill_start.busy", {31'd0, busy_o}, 32'd0);

    // Back-to-back: second start issued in the DONE cycle of the first.
    runAndCheck("b2b_first",  OP_MUL,   32'd3, 32'd5, 32'd15, 33, 1'b0, 1'b0);
    runAndCheck("b2b_second", OP_REMU, 32'd17, 32'd5, 32'd2,  33, 1'b0, 1'b1);

    // Reset mid-RUN: outputs clear at once and no done pulse follows.
    $display("[TB] reset mid-run");
    start_i = 1'b1;
    op_i    = OP_MULHU;
    a_i     = 32'hDEAD_BEEF;
    b_i     = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    rst_n   = 1'b0;
    start_i = 1'b1;
    #1;
    checkOutput("rst_mid.result", result_o, 32'd0);
    checkOutput("rst_mid.busy",   {31'd0, busy_o},  32'd0);
    checkOutput("rst_mid.done",   {31'd0, done_o},  32'd0);
    checkOutput("rst_mid.stall",  {31'd0, stall_o}, 32'd0);
    start_i = 1'b0;
    #5;
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #2;
      if (done_o) done_seen++;
    end
    checkOutput("rst_mid.no_done", 32'(done_seen), 32'd0);

    // Randomized operations with operand scrambling after accept.
    $display("[TB] random");
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      runAndCheck($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb,
                  refResult(rop, ra, rb), refLatency(rop, ra, rb), 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
